// File: rtl/fizzbuzz_sequencer.sv
// Fizz/buzz run controller: takes a divisor/limit config over a valid/ready handshake and
// streams one classified token per count value, using incremental residues rather than modulo.
module fizzbuzz_sequencer #(
   parameter int CNT_W = 8,
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DIV_W-1:0] cfg_fizz,
   input  logic [DIV_W-1:0] cfg_buzz,
   input  logic [CNT_W-1:0] cfg_limit,
   output logic             cfg_err,
   input  logic             start,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_value,
   output logic [1:0]       out_kind,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] fizz_q, fizz_d, buzz_q, buzz_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [DIV_W-1:0] rf_q, rf_d, rb_q, rb_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] value_q, value_d;
   logic [1:0]       kind_q, kind_d;
   logic             err_q, err_d;

   logic             cfg_hs_s, cfg_legal_s;
   logic [DIV_W-1:0] eff_fizz_s, eff_buzz_s;
   logic [DIV_W-1:0] rf_start_s, rb_start_s, rf_step_s, rb_step_s;

   assign cfg_ready = (state_q != ST_RUN);
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign out_valid = valid_q;
   assign out_value = value_q;
   assign out_kind  = kind_q;
   assign cfg_err   = err_q;

   assign cfg_hs_s    = cfg_valid && cfg_ready;
   assign cfg_legal_s = (cfg_fizz != '0) && (cfg_buzz != '0) && (cfg_limit != '0);
   // A run started alongside a legal config handshake must see the new divisors.
   assign eff_fizz_s  = (cfg_hs_s && cfg_legal_s) ? cfg_fizz : fizz_q;
   assign eff_buzz_s  = (cfg_hs_s && cfg_legal_s) ? cfg_buzz : buzz_q;
   assign rf_start_s  = (eff_fizz_s == DIV_W'(1)) ? DIV_W'(0) : DIV_W'(1);
   assign rb_start_s  = (eff_buzz_s == DIV_W'(1)) ? DIV_W'(0) : DIV_W'(1);
   assign rf_step_s   = (rf_q == fizz_q - DIV_W'(1)) ? DIV_W'(0) : rf_q + DIV_W'(1);
   assign rb_step_s   = (rb_q == buzz_q - DIV_W'(1)) ? DIV_W'(0) : rb_q + DIV_W'(1);

   always_comb begin
      state_d = state_q;
      fizz_d  = fizz_q;
      buzz_d  = buzz_q;
      limit_d = limit_q;
      rf_d    = rf_q;
      rb_d    = rb_q;
      valid_d = valid_q;
      value_d = value_q;
      kind_d  = kind_q;
      err_d   = 1'b0;

      if (cfg_hs_s && cfg_legal_s) begin
         fizz_d  = cfg_fizz;
         buzz_d  = cfg_buzz;
         limit_d = cfg_limit;
      end else begin
         err_d = cfg_hs_s;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               valid_d = 1'b1;
               value_d = CNT_W'(1);
               rf_d    = rf_start_s;
               rb_d    = rb_start_s;
               kind_d  = {rb_start_s == DIV_W'(0), rf_start_s == DIV_W'(0)};
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            // Abort withdraws the token even under back-pressure.
            if (abort) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (valid_q && out_ready) begin
               if (value_q == limit_q) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
               end else begin
                  value_d = value_q + CNT_W'(1);
                  rf_d    = rf_step_s;
                  rb_d    = rb_step_s;
                  kind_d  = {rb_step_s == DIV_W'(0), rf_step_s == DIV_W'(0)};
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         fizz_q  <= DIV_W'(3);
         buzz_q  <= DIV_W'(5);
         limit_q <= CNT_W'(100);
         rf_q    <= '0;
         rb_q    <= '0;
         valid_q <= 1'b0;
         value_q <= '0;
         kind_q  <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fizz_q  <= fizz_d;
         buzz_q  <= buzz_d;
         limit_q <= limit_d;
         rf_q    <= rf_d;
         rb_q    <= rb_d;
         valid_q <= valid_d;
         value_q <= value_d;
         kind_q  <= kind_d;
         err_q   <= err_d;
      end
   end

endmodule
